tbm_ctrl: RTL and testbench
===========================

Name: tbm_ctrl

Overview:
Traceback-memory controller for the 8-state (K=4) Viterbi decoder. It owns a 4-bank survivor memory. It sequences ACS decision-vector writes into the banks and schedules traceback jobs. Each job is a training pass over the newer bank followed by a decode pass over the older bank. It drives the traceback unit's enable/selection and the LIFO address for the decoded-bit output buffer.

Parameters:
TB_LEN, 16, words per bank = traceback depth; power of 2, at least 4
AW, 4, log2(TB_LEN); bank address width

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
acs_valid  in  1  ACS presents an 8-bit decision vector this cycle
acs_ready  out  1  controller accepts the write
mem_wr_en  out  1  acs_valid & acs_ready (combinational)
mem_wr_bank  out  2  bank being written
mem_wr_addr  out  AW  word address in mem_wr_bank
mem_rd_en  out  1  survivor-memory read strobe (synchronous RAM, 1-cycle latency)
mem_rd_bank  out  2  bank read
mem_rd_addr  out  AW  word read
tbu_enable  out  1  traceback-unit enable, aligned with read data
tbu_selection  out  1  0 = training, 1 = decode, aligned with read data
tbu_wr_en  in  1  decoded-bit strobe from the traceback unit
out_wr_en  out  1  equals tbu_wr_en
out_wr_addr  out  AW  LIFO write address for the decoded bit
out_buf_sel  out  1  ping-pong output-buffer half
blk_done  out  1  one-cycle pulse when a decoded block is complete
busy  out  1  state is not IDLE

Behaviour:
- Reset (rst=0, async): all registers clear. Output values in reset:
  - acs_ready=1 (held=0).
  - mem_wr_bank=0, mem_wr_addr=0.
  - All read, tbu and out outputs 0.
  - blk_done=0, busy=0.
  - fin_ptr=0, held=0.
- Write side, on mem_wr_en:
  - mem_wr_addr increments.
  - At TB_LEN-1 it wraps to 0, mem_wr_bank increments mod 4, and held increments ("bank complete").
- held (0..4) counts completed, unreleased banks.
  - Decrements in the DONE cycle.
  - Bank complete and DONE in the same cycle leave held unchanged.
- acs_ready = (held != 4). There is no combinational path from acs_valid to acs_ready.
- fin_ptr (2-bit) is the oldest unreleased bank.
  - Job decode bank D = fin_ptr.
  - Job training bank T = fin_ptr+1 mod 4.
- FSM states: IDLE, TRAIN, DECODE, DRAIN, DONE.
  - IDLE: if held >= 2, go to TRAIN. Load rd_cnt = TB_LEN-1 and out_wr_addr = TB_LEN-1.
  - TRAIN: mem_rd_en=1, mem_rd_bank=T, mem_rd_addr=rd_cnt, rd_cnt decrements. When rd_cnt=0, go to DECODE and reload rd_cnt = TB_LEN-1.
  - DECODE: same as TRAIN but on bank D. When rd_cnt=0, go to DRAIN.
  - DRAIN: no reads. Each tbu_wr_en decrements out_wr_addr. A tbu_wr_en with out_wr_addr=0 moves to DONE.
  - DONE (one cycle): blk_done=1, fin_ptr increments, held decrements, out_buf_sel toggles. Go to IDLE.
- tbu_wr_en pulses arriving in DECODE also decrement out_wr_addr. Arrival order is irrelevant; the count governs.
- tbu_enable and tbu_selection are registered, 1 cycle after the address phase.
  - tbu_enable = prior state was TRAIN or DECODE.
  - tbu_selection = prior state was DECODE.
- Job timing:
  - A job is TB_LEN read cycles per phase; IDLE lasts at least 1 cycle between jobs.
  - tbu_enable therefore drops for at least 2 cycles between jobs, which resets the traceback unit to state 0.
- Start latency: TRAIN begins the cycle after held reaches 2.
- tbu_wr_en outside DECODE/DRAIN is ignored. out_wr_en still mirrors it; out_wr_addr is unchanged.
- Reset asserted mid-job aborts immediately; no blk_done is issued.

Test Plan:
1. Assert then release rst → acs_ready=1, busy=0, mem_wr_bank=0, mem_wr_addr=0, tbu_enable=0, blk_done=0.
2. 32 consecutive acs_valid → bank0 addr 0..15, then bank1 addr 0..15. Next cycle TRAIN: rd bank1 addr 15..0. Then DECODE: rd bank0 addr 15..0. tbu_selection is 0 for 16 cycles then 1 for 16, both lagging rd by 1 cycle.
3. Continuous acs_valid with tbu_wr_en tied 0 → after 64 writes held=4, acs_ready=0, mem_wr_en=0; the bank/addr pointer is frozen at bank0 addr0.
4. From case 3, drive 16 tbu_wr_en pulses → out_wr_addr 15..0, a single blk_done, out_buf_sel=1, fin_ptr=1, held=3, acs_ready=1 the next cycle. The next job trains bank2 and decodes bank1.
5. Align a bank completion with the DONE cycle → held is unchanged and the next job starts with the correct T/D.
6. Drop rst in the middle of DECODE → all outputs 0 immediately, no blk_done. After release, behaviour matches case 1.

Source files
------------

// File: rtl/tbm_ctrl.sv
// Traceback-memory controller for an 8-state Viterbi decoder: sequences ACS writes into a
// 4-bank survivor memory and schedules train/decode traceback jobs over completed banks.
module tbm_ctrl #(
    parameter int TB_LEN = 16,
    parameter int AW     = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          acs_valid,
    output logic          acs_ready,
    output logic          mem_wr_en,
    output logic [1:0]    mem_wr_bank,
    output logic [AW-1:0] mem_wr_addr,
    output logic          mem_rd_en,
    output logic [1:0]    mem_rd_bank,
    output logic [AW-1:0] mem_rd_addr,
    output logic          tbu_enable,
    output logic          tbu_selection,
    input  logic          tbu_wr_en,
    output logic          out_wr_en,
    output logic [AW-1:0] out_wr_addr,
    output logic          out_buf_sel,
    output logic          blk_done,
    output logic          busy
);

    typedef enum logic [2:0] {IDLE, TRAIN, DECODE, DRAIN, DONE} state_t;

    localparam logic [AW-1:0] LAST = AW'(TB_LEN - 1);

    state_t        state, state_next;
    logic [2:0]    held, held_next;
    logic [1:0]    fin_ptr, wr_bank;
    logic [AW-1:0] wr_addr, rd_cnt, rd_cnt_next, out_addr, out_addr_next;
    logic          out_all, out_all_next;
    logic          buf_sel, tbu_en_q, tbu_sel_q;
    logic          wr_wrap, job_done, out_take;

    assign acs_ready     = (held != 3'd4);
    assign mem_wr_en     = acs_valid & acs_ready;
    assign mem_wr_bank   = wr_bank;
    assign mem_wr_addr   = wr_addr;
    assign wr_wrap       = mem_wr_en && (wr_addr == LAST);
    assign job_done      = (state == DONE);
    assign out_take      = tbu_wr_en && ((state == DECODE) || (state == DRAIN));
    assign out_wr_en     = tbu_wr_en;
    assign out_wr_addr   = out_addr;
    assign out_buf_sel   = buf_sel;
    assign tbu_enable    = tbu_en_q;
    assign tbu_selection = tbu_sel_q;
    assign busy          = (state != IDLE);

    // Bank completion and job release in the same cycle cancel out.
    always_comb begin
        held_next = held;
        if (wr_wrap && !job_done)
            held_next = held + 3'd1;
        else if (!wr_wrap && job_done)
            held_next = held - 3'd1;
    end

    always_comb begin
        state_next    = state;
        rd_cnt_next   = rd_cnt;
        out_addr_next = out_addr;
        out_all_next  = out_all;
        mem_rd_en     = 1'b0;
        mem_rd_bank   = '0;
        mem_rd_addr   = '0;
        blk_done      = 1'b0;
        if (out_take) begin
            out_addr_next = out_addr - AW'(1);
            if (out_addr == '0)
                out_all_next = 1'b1;
        end
        case (state)
            IDLE: begin
                if (held >= 3'd2) begin
                    state_next    = TRAIN;
                    rd_cnt_next   = LAST;
                    out_addr_next = LAST;
                    out_all_next  = 1'b0;
                end
            end
            TRAIN: begin
                mem_rd_en   = 1'b1;
                mem_rd_bank = fin_ptr + 2'd1;
                mem_rd_addr = rd_cnt;
                rd_cnt_next = rd_cnt - AW'(1);
                if (rd_cnt == '0) begin
                    state_next  = DECODE;
                    rd_cnt_next = LAST;
                end
            end
            DECODE: begin
                mem_rd_en   = 1'b1;
                mem_rd_bank = fin_ptr;
                mem_rd_addr = rd_cnt;
                rd_cnt_next = rd_cnt - AW'(1);
                if (rd_cnt == '0)
                    state_next = DRAIN;
            end
            DRAIN: begin
                // The last decoded bit may already have arrived during DECODE.
                if (out_all || (out_take && (out_addr == '0)))
                    state_next = DONE;
            end
            DONE: begin
                blk_done   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            held      <= '0;
            fin_ptr   <= '0;
            wr_bank   <= '0;
            wr_addr   <= '0;
            rd_cnt    <= '0;
            out_addr  <= '0;
            out_all   <= 1'b0;
            buf_sel   <= 1'b0;
            tbu_en_q  <= 1'b0;
            tbu_sel_q <= 1'b0;
        end else begin
            state     <= state_next;
            held      <= held_next;
            rd_cnt    <= rd_cnt_next;
            out_addr  <= out_addr_next;
            out_all   <= out_all_next;
            tbu_en_q  <= (state == TRAIN) || (state == DECODE);
            tbu_sel_q <= (state == DECODE);
            if (mem_wr_en) begin
                wr_addr <= wr_addr + AW'(1);
                if (wr_addr == LAST)
                    wr_bank <= wr_bank + 2'd1;
            end
            if (job_done) begin
                fin_ptr <= fin_ptr + 2'd1;
                buf_sel <= ~buf_sel;
            end
        end
    end

endmodule

// File: tb/tb_tbm_ctrl.sv
// Directed bench for tbm_ctrl: write sequencing, job scheduling, backpressure,
// block release, completion/release collision and mid-job reset.
module tb_tbm_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       acs_valid, tbu_wr_en;
    logic       acs_ready, mem_wr_en, mem_rd_en, tbu_enable, tbu_selection;
    logic       out_wr_en, out_buf_sel, blk_done, busy;
    logic [1:0] mem_wr_bank, mem_rd_bank;
    logic [3:0] mem_wr_addr, mem_rd_addr, out_wr_addr;

    int total = 0;
    int bad   = 0;

    tbm_ctrl #(.TB_LEN(16), .AW(4)) dut (
        .clk(clk), .rst(rst), .acs_valid(acs_valid), .acs_ready(acs_ready),
        .mem_wr_en(mem_wr_en), .mem_wr_bank(mem_wr_bank), .mem_wr_addr(mem_wr_addr),
        .mem_rd_en(mem_rd_en), .mem_rd_bank(mem_rd_bank), .mem_rd_addr(mem_rd_addr),
        .tbu_enable(tbu_enable), .tbu_selection(tbu_selection), .tbu_wr_en(tbu_wr_en),
        .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr), .out_buf_sel(out_buf_sel),
        .blk_done(blk_done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [6:0] got;
        rst = 1'b0; acs_valid = 1'b0; tbu_wr_en = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        got = {acs_ready, busy, mem_wr_bank, mem_wr_addr == 4'd0, tbu_enable, blk_done};
        total++;
        if (got !== 7'b1000100) begin
            bad++; $display("FAIL reset_held got=%b exp=%b", got, 7'b1000100);
        end
        rst = 1'b1;
        tick;
        @(negedge clk);
        got = {acs_ready, busy, mem_wr_bank, mem_wr_addr == 4'd0, tbu_enable, blk_done};
        total++;
        if (got !== 7'b1000100) begin
            bad++; $display("FAIL reset_release got=%b exp=%b", got, 7'b1000100);
        end
        tick;
    endtask

    task automatic test_first_job;
        logic [7:0] got, exp;
        logic [9:0] rgot, rexp;
        for (int i = 0; i < 32; i++) begin
            acs_valid = 1'b1;
            @(negedge clk);
            got = {mem_wr_en, acs_ready, mem_wr_bank, mem_wr_addr};
            exp = {1'b1, 1'b1, 2'(i / 16), 4'(i % 16)};
            total++;
            if (got !== exp) begin
                bad++; $display("FAIL write_seq i=%0d got=%h exp=%h", i, got, exp);
            end
            tick;
        end
        acs_valid = 1'b0;
        @(negedge clk);
        total++;
        if ({busy, mem_rd_en} !== 2'b00) begin
            bad++; $display("FAIL start_latency busy/rd got=%b exp=00", {busy, mem_rd_en});
        end
        tick;
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            rgot = {mem_rd_en, mem_rd_bank, mem_rd_addr, tbu_enable, tbu_selection, busy};
            rexp = {1'b1, (c < 16) ? 2'd1 : 2'd0, 4'(15 - (c % 16)), c > 0, c > 16, 1'b1};
            total++;
            if (rgot !== rexp) begin
                bad++; $display("FAIL job1_read c=%0d got=%b exp=%b", c, rgot, rexp);
            end
            tick;
        end
        @(negedge clk);
        total++;
        if ({mem_rd_en, tbu_enable, tbu_selection, busy} !== 4'b0111) begin
            bad++; $display("FAIL drain_entry got=%b exp=0111", {mem_rd_en, tbu_enable, tbu_selection, busy});
        end
        tick;
    endtask

    task automatic test_backpressure;
        logic [7:0] got, exp;
        for (int i = 0; i < 32; i++) begin
            acs_valid = 1'b1;
            @(negedge clk);
            got = {mem_wr_en, acs_ready, mem_wr_bank, mem_wr_addr};
            exp = {1'b1, 1'b1, 2'(2 + i / 16), 4'(i % 16)};
            total++;
            if (got !== exp) begin
                bad++; $display("FAIL fill_seq i=%0d got=%h exp=%h", i, got, exp);
            end
            tick;
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            got = {acs_ready, mem_wr_en, mem_wr_bank, mem_wr_addr};
            total++;
            if ({got, busy} !== 9'b000000001) begin
                bad++; $display("FAIL full_stall k=%0d got=%b exp=000000001", k, {got, busy});
            end
            tick;
        end
        acs_valid = 1'b0;
    endtask

    task automatic test_release;
        logic [6:0] got, exp;
        for (int k = 0; k < 16; k++) begin
            tbu_wr_en = 1'b1;
            @(negedge clk);
            got = {out_wr_en, out_wr_addr, blk_done, busy};
            exp = {1'b1, 4'(15 - k), 1'b0, 1'b1};
            total++;
            if (got !== exp) begin
                bad++; $display("FAIL drain_lifo k=%0d got=%b exp=%b", k, got, exp);
            end
            tick;
        end
        tbu_wr_en = 1'b0;
        @(negedge clk);
        total++;
        if ({blk_done, out_buf_sel, acs_ready, busy} !== 4'b1001) begin
            bad++; $display("FAIL done_cycle got=%b exp=1001", {blk_done, out_buf_sel, acs_ready, busy});
        end
        tick;
        @(negedge clk);
        total++;
        if ({blk_done, out_buf_sel, acs_ready, busy, mem_rd_en} !== 5'b01100) begin
            bad++; $display("FAIL after_done got=%b exp=01100", {blk_done, out_buf_sel, acs_ready, busy, mem_rd_en});
        end
        tick;
        @(negedge clk);
        total++;
        if ({mem_rd_en, mem_rd_bank, mem_rd_addr, tbu_enable} !== 8'b1_10_1111_0) begin
            bad++; $display("FAIL job2_train_start got=%b exp=%b", {mem_rd_en, mem_rd_bank, mem_rd_addr, tbu_enable}, 8'b11011110);
        end
        tick;
    endtask

    task automatic test_done_collision;
        logic [6:0] rgot, rexp;
        for (int c = 1; c < 32; c++) begin
            acs_valid = (c <= 15);
            tbu_wr_en = (c >= 28);
            @(negedge clk);
            rgot = {mem_rd_en, mem_rd_bank, mem_rd_addr};
            rexp = {1'b1, (c < 16) ? 2'd2 : 2'd1, 4'(15 - (c % 16))};
            total++;
            if (rgot !== rexp) begin
                bad++; $display("FAIL job2_read c=%0d got=%b exp=%b", c, rgot, rexp);
            end
            if (c <= 15) begin
                total++;
                if ({mem_wr_en, mem_wr_bank, mem_wr_addr} !== {1'b1, 2'd0, 4'(c - 1)}) begin
                    bad++; $display("FAIL overlap_write c=%0d got=%b exp=%b", c, {mem_wr_en, mem_wr_bank, mem_wr_addr}, {1'b1, 2'd0, 4'(c - 1)});
                end
            end
            if (c >= 28) begin
                total++;
                if (out_wr_addr !== 4'(43 - c)) begin
                    bad++; $display("FAIL decode_lifo c=%0d got=%0d exp=%0d", c, out_wr_addr, 43 - c);
                end
            end
            tick;
        end
        acs_valid = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tbu_wr_en = 1'b1;
            @(negedge clk);
            total++;
            if ({out_wr_addr, mem_rd_en, blk_done} !== {4'(11 - k), 2'b00}) begin
                bad++; $display("FAIL drain2_lifo k=%0d got=%b exp=%b", k, {out_wr_addr, mem_rd_en, blk_done}, {4'(11 - k), 2'b00});
            end
            tick;
        end
        tbu_wr_en = 1'b0;
        acs_valid = 1'b1;
        @(negedge clk);
        total++;
        if ({blk_done, mem_wr_en, mem_wr_bank, mem_wr_addr} !== 8'b1_1_00_1111) begin
            bad++; $display("FAIL collide_done got=%b exp=11001111", {blk_done, mem_wr_en, mem_wr_bank, mem_wr_addr});
        end
        tick;
        acs_valid = 1'b0;
        @(negedge clk);
        total++;
        if ({mem_wr_bank, mem_wr_addr, busy, acs_ready, out_buf_sel} !== 9'b01_0000_010) begin
            bad++; $display("FAIL collide_idle got=%b exp=010000010", {mem_wr_bank, mem_wr_addr, busy, acs_ready, out_buf_sel});
        end
        tick;
        @(negedge clk);
        total++;
        if ({mem_rd_en, mem_rd_bank, mem_rd_addr} !== 7'b1_11_1111) begin
            bad++; $display("FAIL job3_train_start got=%b exp=1111111", {mem_rd_en, mem_rd_bank, mem_rd_addr});
        end
        tick;
        for (int c = 1; c <= 16; c++) begin
            acs_valid = 1'b1;
            @(negedge clk);
            rgot = {mem_rd_en, mem_rd_bank, mem_rd_addr};
            rexp = {1'b1, (c < 16) ? 2'd3 : 2'd2, 4'(15 - (c % 16))};
            total++;
            if ({acs_ready, mem_wr_en, mem_wr_bank, mem_wr_addr, rgot} !== {2'b11, 2'd1, 4'(c - 1), rexp}) begin
                bad++; $display("FAIL held_after_collide c=%0d got=%b exp=%b", c, {acs_ready, mem_wr_en, mem_wr_bank, mem_wr_addr, rgot}, {2'b11, 2'd1, 4'(c - 1), rexp});
            end
            tick;
        end
        @(negedge clk);
        total++;
        if ({acs_ready, mem_wr_en, mem_rd_bank, mem_rd_addr} !== 8'b00_10_1110) begin
            bad++; $display("FAIL full_again got=%b exp=00101110", {acs_ready, mem_wr_en, mem_rd_bank, mem_rd_addr});
        end
        tick;
        acs_valid = 1'b0;
    endtask

    task automatic test_reset_mid_decode;
        logic [24:0] got;
        @(negedge clk);
        total++;
        if ({mem_rd_en, mem_rd_bank, mem_rd_addr, tbu_selection} !== 8'b1_10_1101_1) begin
            bad++; $display("FAIL pre_abort got=%b exp=11011011", {mem_rd_en, mem_rd_bank, mem_rd_addr, tbu_selection});
        end
        #1 rst = 1'b0;
        #1;
        got = {acs_ready, mem_wr_en, mem_wr_bank, mem_wr_addr, mem_rd_en, mem_rd_bank, mem_rd_addr,
               tbu_enable, tbu_selection, out_wr_en, out_wr_addr, out_buf_sel, blk_done, busy};
        total++;
        if (got !== {1'b1, 24'd0}) begin
            bad++; $display("FAIL async_abort got=%b exp=%b", got, {1'b1, 24'd0});
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            total++;
            if ({blk_done, busy} !== 2'b00) begin
                bad++; $display("FAIL abort_no_done k=%0d got=%b exp=00", k, {blk_done, busy});
            end
        end
        rst = 1'b1;
        tick;
        acs_valid = 1'b1;
        @(negedge clk);
        total++;
        if ({acs_ready, busy, mem_wr_en, mem_wr_bank, mem_wr_addr, tbu_enable, blk_done} !== 11'b101_00_0000_00) begin
            bad++; $display("FAIL post_abort got=%b exp=10100000000", {acs_ready, busy, mem_wr_en, mem_wr_bank, mem_wr_addr, tbu_enable, blk_done});
        end
        tick;
        acs_valid = 1'b0;
    endtask

    initial begin
        test_reset;
        test_first_job;
        test_backpressure;
        test_release;
        test_done_collision;
        test_reset_mid_decode;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
